// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo driver: direction command encoding.
package servo_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

endpackage

// File: rtl/servo_multi_driver_channel.sv
// One servo channel: samples direction/enable, steps a saturating position once per frame
// and drives a glitch-free PWM output from the width latched at the frame boundary.
module servo_channel
  import servo_pkg::*;
#(
  parameter int PW_MIN   = 500,
  parameter int PW_MAX   = 2500,
  parameter int PW_RESET = 1500,
  parameter int STEP     = 10,
  parameter int PW_W     = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [1:0]      i_dir,
  input  logic            i_frame_wrap,
  input  logic [PW_W-1:0] i_frame_cnt,
  output logic            o_servo,
  output logic [PW_W-1:0] o_position,
  output logic            o_limit_cw,
  output logic            o_limit_ccw
);

  localparam logic [PW_W-1:0] MIN_C  = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] MAX_C  = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] RST_C  = PW_W'(PW_RESET);
  localparam logic [PW_W:0]   STEP_X = (PW_W+1)'(STEP);
  localparam logic [PW_W:0]   MIN_X  = {1'b0, MIN_C};
  localparam logic [PW_W:0]   MAX_X  = {1'b0, MAX_C};

  logic [1:0]      r_dir_q;
  logic            r_en_q;
  logic [PW_W-1:0] r_pos;
  logic [PW_W-1:0] r_pw_lat;
  logic            r_en_lat;
  logic            r_limit_cw;
  logic            r_limit_ccw;
  logic            r_servo;
  logic [PW_W:0]   w_up;
  logic [PW_W:0]   w_dn;
  logic [PW_W-1:0] w_pos_next;

  // One extra bit keeps the sum/difference free of wrap-around before saturation.
  assign w_up = {1'b0, r_pos} + STEP_X;
  assign w_dn = {1'b0, r_pos} - STEP_X;

  always_comb begin
    w_pos_next = r_pos;
    if (r_en_q) begin
      case (r_dir_q)
        DIR_CW: begin
          if (w_up > MAX_X) w_pos_next = MAX_C;
          else              w_pos_next = w_up[PW_W-1:0];
        end
        DIR_CCW: begin
          if (w_dn[PW_W] || (w_dn < MIN_X)) w_pos_next = MIN_C;
          else                              w_pos_next = w_dn[PW_W-1:0];
        end
        default: w_pos_next = r_pos;
      endcase
    end else begin
      w_pos_next = r_pos;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir_q <= DIR_STOP;
      r_en_q  <= 1'b0;
    end else begin
      r_dir_q <= i_dir;
      r_en_q  <= i_en;
    end
  end

  // Position, frame width and limit flags change only on the frame boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos       <= RST_C;
      r_pw_lat    <= RST_C;
      r_en_lat    <= 1'b0;
      r_limit_cw  <= (RST_C == MAX_C);
      r_limit_ccw <= (RST_C == MIN_C);
    end else if (i_frame_wrap) begin
      r_pos       <= w_pos_next;
      r_pw_lat    <= w_pos_next;
      r_en_lat    <= r_en_q;
      r_limit_cw  <= (w_pos_next == MAX_C);
      r_limit_ccw <= (w_pos_next == MIN_C);
    end else begin
      r_pos       <= r_pos;
      r_pw_lat    <= r_pw_lat;
      r_en_lat    <= r_en_lat;
      r_limit_cw  <= r_limit_cw;
      r_limit_ccw <= r_limit_ccw;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_servo <= 1'b0;
    else          r_servo <= r_en_lat && (i_frame_cnt < r_pw_lat);
  end

  assign o_servo     = r_servo;
  assign o_position  = r_pos;
  assign o_limit_cw  = r_limit_cw;
  assign o_limit_ccw = r_limit_ccw;

endmodule

// File: rtl/servo_multi_driver.sv
// NCH-channel PWM servo driver: shared 1 us prescaler and frame counter feeding
// independent saturating position channels.
module servo_multi_driver
  import servo_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DIV       = 100,
  parameter int PERIOD_US = 20000,
  parameter int PW_MIN    = 500,
  parameter int PW_MAX    = 2500,
  parameter int PW_RESET  = 1500,
  parameter int STEP      = 10,
  parameter int PW_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NCH-1:0]       i_en,
  input  logic [2*NCH-1:0]     i_dir,
  output logic [NCH-1:0]       o_servo,
  output logic [NCH*PW_W-1:0]  o_position,
  output logic [NCH-1:0]       o_limit_cw,
  output logic [NCH-1:0]       o_limit_ccw,
  output logic                 o_frame_stb
);

  localparam int                PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [PW_W-1:0]    FRAME_LAST = PW_W'(PERIOD_US - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [PW_W-1:0]    r_frame_cnt;
  logic               r_frame_stb;
  logic               w_tick;
  logic               w_wrap;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_frame_cnt == FRAME_LAST);

  // Shared timebase: 1 us tick, frame counter and its one-cycle wrap strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc     <= '0;
      r_frame_cnt <= '0;
      r_frame_stb <= 1'b0;
    end else begin
      if (w_tick) r_presc <= '0;
      else        r_presc <= r_presc + PRESC_W'(1'b1);
      if (w_wrap)      r_frame_cnt <= '0;
      else if (w_tick) r_frame_cnt <= r_frame_cnt + PW_W'(1'b1);
      else             r_frame_cnt <= r_frame_cnt;
      r_frame_stb <= w_wrap;
    end
  end

  assign o_frame_stb = r_frame_stb;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    servo_channel #(
      .PW_MIN   (PW_MIN),
      .PW_MAX   (PW_MAX),
      .PW_RESET (PW_RESET),
      .STEP     (STEP),
      .PW_W     (PW_W)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en[g]),
      .i_dir        (i_dir[2*g +: 2]),
      .i_frame_wrap (w_wrap),
      .i_frame_cnt  (r_frame_cnt),
      .o_servo      (o_servo[g]),
      .o_position   (o_position[g*PW_W +: PW_W]),
      .o_limit_cw   (o_limit_cw[g]),
      .o_limit_ccw  (o_limit_ccw[g])
    );
  end

endmodule

// File: tb/tb_servo_multi_driver.sv
// Directed self-checking bench for servo_multi_driver (NCH=2, DIV=2, 100-tick frame, 10..30 range, step 5).
module tb_servo_multi_driver;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [3:0]  dir;
  logic [1:0]  servo;
  logic [31:0] position;
  logic [1:0]  limit_cw;
  logic [1:0]  limit_ccw;
  logic        frame_stb;

  int checks;
  int failures;

  servo_multi_driver #(
    .NCH(2), .DIV(2), .PERIOD_US(100), .PW_MIN(10), .PW_MAX(30),
    .PW_RESET(20), .STEP(5), .PW_W(16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_dir       (dir),
    .o_servo     (servo),
    .o_position  (position),
    .o_limit_cw  (limit_cw),
    .o_limit_ccw (limit_ccw),
    .o_frame_stb (frame_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next negedge on which FRAME_STB is high; n = negedges waited (capped at 400).
  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_stb && n < 400);
  endtask

  // Count SERVO-high samples over one 200-CLK frame; optionally change DIR at sample mid_at.
  task automatic measure_frame(input int mid_at, input logic [3:0] mid_dir,
                               output int h0, output int h1, output logic stb_end);
    h0 = 0;
    h1 = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == mid_at) dir = mid_dir;
      if (servo[0]) h0++;
      if (servo[1]) h1++;
    end
    stb_end = frame_stb;
  endtask

  task automatic test_reset;
    int n, h0, h1;
    logic s;
    rst_n = 1'b0;
    en    = 2'b11;
    dir   = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (servo !== 2'b00 || frame_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: servo=%b stb=%b, required 00/0", servo, frame_stb);
    end
    checks++;
    if (position !== {16'd20, 16'd20} || limit_cw !== 2'b00 || limit_ccw !== 2'b00) begin
      failures++;
      $display("FAIL reset_position: pos=%h lcw=%b lccw=%b, required 00140014/00/00",
               position, limit_cw, limit_ccw);
    end
    rst_n = 1'b1;
    wait_wrap(n);
    checks++;
    if (n !== 200) begin
      failures++;
      $display("FAIL reset_first_wrap: %0d cycles, required 200", n);
    end
    measure_frame(0, 4'b0000, h0, h1, s);
    checks++;
    if (h0 !== 40 || h1 !== 40 || s !== 1'b1) begin
      failures++;
      $display("FAIL reset_pulse: high=%0d/%0d stb=%b, required 40/40/1", h0, h1, s);
    end
  endtask

  task automatic test_cw;
    int n;
    logic [15:0] exp_p[3];
    logic        exp_l[3];
    exp_p = '{16'd25, 16'd30, 16'd30};
    exp_l = '{1'b0, 1'b1, 1'b1};
    dir = 4'b0001;
    for (int f = 0; f < 3; f++) begin
      wait_wrap(n);
      checks++;
      if (n !== 200 || position[15:0] !== exp_p[f] || limit_cw[0] !== exp_l[f] ||
          position[31:16] !== 16'd20) begin
        failures++;
        $display("FAIL cw_frame%0d: n=%0d pos0=%0d lcw0=%b pos1=%0d, required 200/%0d/%b/20",
                 f, n, position[15:0], limit_cw[0], position[31:16], exp_p[f], exp_l[f]);
      end
    end
    dir = 4'b0000;
  endtask

  task automatic test_ccw;
    int n, h0, h1;
    logic s;
    logic [15:0] exp_p[3];
    logic        exp_l[3];
    exp_p = '{16'd15, 16'd10, 16'd10};
    exp_l = '{1'b0, 1'b1, 1'b1};
    dir = 4'b1000;
    for (int f = 0; f < 3; f++) begin
      wait_wrap(n);
      checks++;
      if (n !== 200 || position[31:16] !== exp_p[f] || limit_ccw[1] !== exp_l[f] ||
          position[15:0] !== 16'd30) begin
        failures++;
        $display("FAIL ccw_frame%0d: n=%0d pos1=%0d lccw1=%b pos0=%0d, required 200/%0d/%b/30",
                 f, n, position[31:16], limit_ccw[1], position[15:0], exp_p[f], exp_l[f]);
      end
    end
    dir = 4'b0000;
    measure_frame(0, 4'b0000, h0, h1, s);
    checks++;
    if (h0 !== 60 || h1 !== 20 || s !== 1'b1) begin
      failures++;
      $display("FAIL ccw_pulse: high=%0d/%0d stb=%b, required 60/20/1", h0, h1, s);
    end
  endtask

  task automatic test_mid_toggle;
    int n, h0, h1;
    logic s;
    dir = 4'b0100;
    wait_wrap(n);
    checks++;
    if (n !== 200 || position[31:16] !== 16'd15) begin
      failures++;
      $display("FAIL toggle_step: n=%0d pos1=%0d, required 200/15", n, position[31:16]);
    end
    measure_frame(50, 4'b1000, h0, h1, s);
    checks++;
    if (h1 !== 30 || h0 !== 60 || s !== 1'b1) begin
      failures++;
      $display("FAIL toggle_pulse: high=%0d/%0d stb=%b, required 60/30/1", h0, h1, s);
    end
    checks++;
    if (position[31:16] !== 16'd10) begin
      failures++;
      $display("FAIL toggle_apply: pos1=%0d, required 10", position[31:16]);
    end
    dir = 4'b0000;
  endtask

  task automatic test_enable;
    int n, h0, h1;
    logic s;
    en  = 2'b10;
    dir = 4'b0010;
    wait_wrap(n);
    measure_frame(0, 4'b0010, h0, h1, s);
    checks++;
    if (h0 !== 0 || h1 !== 20 || s !== 1'b1) begin
      failures++;
      $display("FAIL en_off_pulse: high=%0d/%0d stb=%b, required 0/20/1", h0, h1, s);
    end
    checks++;
    if (position[15:0] !== 16'd30) begin
      failures++;
      $display("FAIL en_off_frozen: pos0=%0d, required 30", position[15:0]);
    end
    en = 2'b11;
    wait_wrap(n);
    checks++;
    if (n !== 200 || position[15:0] !== 16'd25 || limit_cw[0] !== 1'b0) begin
      failures++;
      $display("FAIL en_resume: n=%0d pos0=%0d lcw0=%b, required 200/25/0", n, position[15:0], limit_cw[0]);
    end
    measure_frame(0, 4'b0010, h0, h1, s);
    checks++;
    if (h0 !== 50 || position[15:0] !== 16'd20 || s !== 1'b1) begin
      failures++;
      $display("FAIL en_resume_pulse: high0=%0d pos0=%0d stb=%b, required 50/20/1", h0, position[15:0], s);
    end
    dir = 4'b0000;
  endtask

  task automatic test_reset_mid;
    int n, h0, h1;
    logic s;
    wait_wrap(n);
    repeat (10) @(negedge clk);
    checks++;
    if (servo !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pre: servo=%b, required 11", servo);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (servo !== 2'b00 || position !== {16'd20, 16'd20} || limit_ccw !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_async: servo=%b pos=%h lccw=%b, required 00/00140014/00", servo, position, limit_ccw);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_wrap(n);
    checks++;
    if (n !== 200) begin
      failures++;
      $display("FAIL rst_mid_restart: %0d cycles, required 200", n);
    end
    measure_frame(0, 4'b0000, h0, h1, s);
    checks++;
    if (h0 !== 40 || h1 !== 40 || s !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pulse: high=%0d/%0d stb=%b, required 40/40/1", h0, h1, s);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 2'b00;
    dir      = 4'b0000;
    test_reset;
    test_cw;
    test_ccw;
    test_mid_toggle;
    test_enable;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
